// File: rtl/quad_evt_if.sv
// Step-event handshake between the quadrature position block and its consumer.
// The producer holds evt_valid/evt_dir until the consumer raises evt_ready.
interface quad_evt_if;
    logic evt_valid;
    logic evt_dir;
    logic evt_ready;

    modport master (output evt_valid, output evt_dir, input evt_ready);
    modport slave  (input evt_valid, input evt_dir, output evt_ready);
endinterface

// File: rtl/quad_pos_ctrl.sv
// Quadrature decoder with saturating detent position counter and a buffered
// single-entry step event that reports dropped events and illegal transitions.
module quad_pos_ctrl #(
    parameter int WIDTH   = 8,
    parameter int MAX_POS = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             a,
    input  logic             b,
    output logic [WIDTH-1:0] pos,
    output logic             at_min,
    output logic             at_max,
    output logic             evt_ovf,
    output logic             err,
    quad_evt_if.master       evt
);

    localparam logic [WIDTH-1:0] MAX_P = WIDTH'(MAX_POS);

    logic [1:0]        cur_ab;
    logic [1:0]        prev_ab;
    logic [1:0]        idx_cur;
    logic [1:0]        idx_prev;
    logic [1:0]        diff;
    logic signed [3:0] phase;
    logic signed [3:0] delta;
    logic signed [3:0] phase_sum;
    logic signed [3:0] phase_nxt;
    logic              illegal;
    logic              step_cw;
    logic              step_ccw;
    logic              step_any;
    logic [WIDTH-1:0]  pos_nxt;
    logic              evt_valid_q;
    logic              evt_dir_q;

    function automatic logic [WIDTH-1:0] sat_step(input logic [WIDTH-1:0] p,
                                                  input logic cw);
        if (cw) return (p == MAX_P) ? p : p + WIDTH'(1);
        else    return (p == '0)    ? p : p - WIDTH'(1);
    endfunction

    // Gray sequence 00,01,11,10 mapped to 0..3 so a CW move is +1 mod 4.
    assign cur_ab   = {a, b};
    assign idx_cur  = {cur_ab[1], cur_ab[1] ^ cur_ab[0]};
    assign idx_prev = {prev_ab[1], prev_ab[1] ^ prev_ab[0]};
    assign diff     = idx_cur - idx_prev;

    always_comb begin
        delta   = 4'sd0;
        illegal = 1'b0;
        case (diff)
            2'd1:    delta   = 4'sd1;
            2'd3:    delta   = -4'sd1;
            2'd2:    illegal = 1'b1;
            default: delta   = 4'sd0;
        endcase
    end

    assign phase_sum = phase + delta;
    assign step_cw   = en && !illegal && (phase_sum == 4'sd4);
    assign step_ccw  = en && !illegal && (phase_sum == -4'sd4);
    assign step_any  = step_cw || step_ccw;

    always_comb begin
        phase_nxt = phase_sum;
        if (illegal || step_any) phase_nxt = 4'sd0;
    end

    always_comb begin
        pos_nxt = pos;
        if (clr)           pos_nxt = '0;
        else if (step_any) pos_nxt = sat_step(pos, step_cw);
    end

    always_ff @(posedge clk) begin
        prev_ab <= cur_ab;
        if (rst) begin
            pos         <= '0;
            at_min      <= 1'b1;
            at_max      <= 1'b0;
            phase       <= 4'sd0;
            evt_valid_q <= 1'b0;
            evt_dir_q   <= 1'b0;
            evt_ovf     <= 1'b0;
            err         <= 1'b0;
        end else begin
            pos    <= pos_nxt;
            at_min <= (pos_nxt == '0);
            at_max <= (pos_nxt == MAX_P);
            if (clr) begin
                phase       <= 4'sd0;
                evt_valid_q <= 1'b0;
                evt_ovf     <= 1'b0;
                err         <= 1'b0;
            end else begin
                if (en) begin
                    phase <= phase_nxt;
                    if (illegal) err <= 1'b1;
                end
                // A new step replaces the event only if the slot is free or being accepted.
                if (step_any) begin
                    if (!evt_valid_q || evt.evt_ready) begin
                        evt_valid_q <= 1'b1;
                        evt_dir_q   <= step_cw;
                    end else begin
                        evt_ovf <= 1'b1;
                    end
                end else if (evt_valid_q && evt.evt_ready) begin
                    evt_valid_q <= 1'b0;
                end
            end
        end
    end

    assign evt.evt_valid = evt_valid_q;
    assign evt.evt_dir   = evt_dir_q;

endmodule

// File: tb/tb_quad_pos_ctrl.sv
// Directed bench for quad_pos_ctrl: detent stepping, saturation, jitter,
// event handshake/overflow, error detection, enable gating, clear and reset.
module tb_quad_pos_ctrl;

    logic       clk = 1'b0;
    logic       rst, en, clr, a, b;
    logic [7:0] pos;
    logic       at_min, at_max, evt_ovf, err;
    int         n_cmp = 0;
    int         n_fail = 0;

    quad_evt_if evt_bus();

    quad_pos_ctrl #(.WIDTH(8), .MAX_POS(255)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .a(a), .b(b),
        .pos(pos), .at_min(at_min), .at_max(at_max),
        .evt_ovf(evt_ovf), .err(err), .evt(evt_bus.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_ab(input logic [1:0] v);
        {a, b} = v;
        tick();
    endtask

    task automatic cw_detent();
        step_ab(2'b01); step_ab(2'b11); step_ab(2'b10); step_ab(2'b00);
    endtask

    task automatic ccw_detent();
        step_ab(2'b10); step_ab(2'b11); step_ab(2'b01); step_ab(2'b00);
    endtask

    task automatic do_clr();
        clr = 1'b1; tick(); clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; clr = 1'b0; a = 1'b0; b = 1'b0; evt_bus.evt_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        n_cmp++; if (pos !== 8'd0) begin n_fail++; $display("FAIL rst_pos got %0d want 0", pos); end
        n_cmp++; if (at_min !== 1'b1) begin n_fail++; $display("FAIL rst_at_min got %b want 1", at_min); end
        n_cmp++; if (at_max !== 1'b0) begin n_fail++; $display("FAIL rst_at_max got %b want 0", at_max); end
        n_cmp++; if (evt_bus.evt_valid !== 1'b0) begin n_fail++; $display("FAIL rst_evt_valid got %b want 0", evt_bus.evt_valid); end
        n_cmp++; if (evt_bus.evt_dir !== 1'b0) begin n_fail++; $display("FAIL rst_evt_dir got %b want 0", evt_bus.evt_dir); end
        n_cmp++; if (evt_ovf !== 1'b0) begin n_fail++; $display("FAIL rst_evt_ovf got %b want 0", evt_ovf); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b want 0", err); end
    endtask

    task automatic test_cw_detent();
        // One quadrature change every 4 cycles.
        {a, b} = 2'b01; repeat (4) tick();
        {a, b} = 2'b11; repeat (4) tick();
        {a, b} = 2'b10; repeat (4) tick();
        n_cmp++; if (pos !== 8'd0) begin n_fail++; $display("FAIL cw_partial_pos got %0d want 0", pos); end
        n_cmp++; if (evt_bus.evt_valid !== 1'b0) begin n_fail++; $display("FAIL cw_partial_valid got %b want 0", evt_bus.evt_valid); end
        {a, b} = 2'b00; tick();
        n_cmp++; if (pos !== 8'd1) begin n_fail++; $display("FAIL cw_pos got %0d want 1", pos); end
        n_cmp++; if (evt_bus.evt_valid !== 1'b1) begin n_fail++; $display("FAIL cw_valid got %b want 1", evt_bus.evt_valid); end
        n_cmp++; if (evt_bus.evt_dir !== 1'b1) begin n_fail++; $display("FAIL cw_dir got %b want 1", evt_bus.evt_dir); end
        n_cmp++; if (at_min !== 1'b0) begin n_fail++; $display("FAIL cw_at_min got %b want 0", at_min); end
        repeat (3) tick();
        n_cmp++; if (evt_bus.evt_valid !== 1'b1) begin n_fail++; $display("FAIL cw_valid_hold got %b want 1", evt_bus.evt_valid); end
        evt_bus.evt_ready = 1'b1; tick(); evt_bus.evt_ready = 1'b0;
        n_cmp++; if (evt_bus.evt_valid !== 1'b0) begin n_fail++; $display("FAIL cw_accept got %b want 0", evt_bus.evt_valid); end
    endtask

    task automatic test_saturation();
        evt_bus.evt_ready = 1'b1;
        repeat (254) cw_detent();
        n_cmp++; if (pos !== 8'd255) begin n_fail++; $display("FAIL sat_reach got %0d want 255", pos); end
        n_cmp++; if (at_max !== 1'b1) begin n_fail++; $display("FAIL sat_at_max got %b want 1", at_max); end
        cw_detent();
        n_cmp++; if (pos !== 8'd255) begin n_fail++; $display("FAIL sat_hold got %0d want 255", pos); end
        n_cmp++; if (at_max !== 1'b1) begin n_fail++; $display("FAIL sat_hold_at_max got %b want 1", at_max); end
        n_cmp++; if (evt_bus.evt_valid !== 1'b1 || evt_bus.evt_dir !== 1'b1) begin n_fail++; $display("FAIL sat_evt got %b%b want 11", evt_bus.evt_valid, evt_bus.evt_dir); end
        ccw_detent();
        n_cmp++; if (pos !== 8'd254) begin n_fail++; $display("FAIL sat_ccw got %0d want 254", pos); end
        n_cmp++; if (evt_bus.evt_dir !== 1'b0) begin n_fail++; $display("FAIL sat_ccw_dir got %b want 0", evt_bus.evt_dir); end
        n_cmp++; if (at_max !== 1'b0) begin n_fail++; $display("FAIL sat_ccw_at_max got %b want 0", at_max); end
        evt_bus.evt_ready = 1'b0;
        do_clr();
        n_cmp++; if (pos !== 8'd0 || at_min !== 1'b1) begin n_fail++; $display("FAIL clr_pos got %0d/%b want 0/1", pos, at_min); end
        // CCW at zero holds but still reports an event.
        ccw_detent();
        n_cmp++; if (pos !== 8'd0 || evt_bus.evt_valid !== 1'b1 || evt_bus.evt_dir !== 1'b0) begin n_fail++; $display("FAIL min_hold got %0d/%b%b want 0/10", pos, evt_bus.evt_valid, evt_bus.evt_dir); end
        do_clr();
    endtask

    task automatic test_jitter();
        step_ab(2'b01); step_ab(2'b00); step_ab(2'b01); step_ab(2'b11); step_ab(2'b10);
        n_cmp++; if (pos !== 8'd0) begin n_fail++; $display("FAIL jit_partial got %0d want 0", pos); end
        step_ab(2'b00);
        n_cmp++; if (pos !== 8'd1) begin n_fail++; $display("FAIL jit_pos got %0d want 1", pos); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL jit_err got %b want 0", err); end
        do_clr();
    endtask

    task automatic test_overflow();
        cw_detent(); cw_detent();
        n_cmp++; if (pos !== 8'd2) begin n_fail++; $display("FAIL ovf_pos got %0d want 2", pos); end
        n_cmp++; if (evt_bus.evt_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_valid got %b want 1", evt_bus.evt_valid); end
        n_cmp++; if (evt_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", evt_ovf); end
        evt_bus.evt_ready = 1'b1; tick(); evt_bus.evt_ready = 1'b0;
        n_cmp++; if (evt_bus.evt_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_accept got %b want 0", evt_bus.evt_valid); end
        tick();
        n_cmp++; if (evt_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", evt_ovf); end
        do_clr();
        n_cmp++; if (evt_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clr got %b want 0", evt_ovf); end
    endtask

    task automatic test_back_to_back();
        cw_detent();
        step_ab(2'b10); step_ab(2'b11); step_ab(2'b01);
        evt_bus.evt_ready = 1'b1;
        step_ab(2'b00);
        evt_bus.evt_ready = 1'b0;
        n_cmp++; if (evt_bus.evt_valid !== 1'b1 || evt_bus.evt_dir !== 1'b0) begin n_fail++; $display("FAIL b2b_evt got %b%b want 10", evt_bus.evt_valid, evt_bus.evt_dir); end
        n_cmp++; if (evt_ovf !== 1'b0 || pos !== 8'd0) begin n_fail++; $display("FAIL b2b_ovf_pos got %b/%0d want 0/0", evt_ovf, pos); end
        do_clr();
    endtask

    task automatic test_err_en();
        step_ab(2'b01);
        step_ab(2'b10);
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set got %b want 1", err); end
        n_cmp++; if (pos !== 8'd0) begin n_fail++; $display("FAIL err_pos got %0d want 0", pos); end
        // Phase was +1 before the illegal move; it must restart from 0.
        step_ab(2'b00); step_ab(2'b01); step_ab(2'b11);
        n_cmp++; if (pos !== 8'd0) begin n_fail++; $display("FAIL err_phase3 got %0d want 0", pos); end
        step_ab(2'b10);
        n_cmp++; if (pos !== 8'd1) begin n_fail++; $display("FAIL err_phase4 got %0d want 1", pos); end
        do_clr();
        n_cmp++; if (err !== 1'b0 || pos !== 8'd0) begin n_fail++; $display("FAIL err_clr got %b/%0d want 0/0", err, pos); end
        en = 1'b0;
        step_ab(2'b00);
        cw_detent();
        step_ab(2'b11);
        step_ab(2'b00);
        n_cmp++; if (pos !== 8'd0 || evt_bus.evt_valid !== 1'b0) begin n_fail++; $display("FAIL en_off got %0d/%b want 0/0", pos, evt_bus.evt_valid); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL en_off_err got %b want 0", err); end
        en = 1'b1;
        tick(); tick();
        n_cmp++; if (pos !== 8'd0 || evt_bus.evt_valid !== 1'b0) begin n_fail++; $display("FAIL en_on got %0d/%b want 0/0", pos, evt_bus.evt_valid); end
        cw_detent(); cw_detent();
        step_ab(2'b11);
        n_cmp++; if (pos !== 8'd2 || err !== 1'b1 || evt_ovf !== 1'b1) begin n_fail++; $display("FAIL pre_clr got %0d/%b/%b want 2/1/1", pos, err, evt_ovf); end
        step_ab(2'b00);
        do_clr();
        n_cmp++; if (pos !== 8'd0 || err !== 1'b0 || evt_ovf !== 1'b0 || evt_bus.evt_valid !== 1'b0) begin n_fail++; $display("FAIL clr_all got %0d/%b/%b/%b want 0/0/0/0", pos, err, evt_ovf, evt_bus.evt_valid); end
    endtask

    task automatic test_rst_mid();
        step_ab(2'b01); step_ab(2'b11);
        rst = 1'b1; tick(); rst = 1'b0;
        step_ab(2'b10); step_ab(2'b00);
        n_cmp++; if (pos !== 8'd0 || evt_bus.evt_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid got %0d/%b want 0/0", pos, evt_bus.evt_valid); end
        step_ab(2'b01);
        n_cmp++; if (pos !== 8'd0) begin n_fail++; $display("FAIL rstmid3 got %0d want 0", pos); end
        step_ab(2'b11);
        n_cmp++; if (pos !== 8'd1 || evt_bus.evt_dir !== 1'b1) begin n_fail++; $display("FAIL rstmid4 got %0d/%b want 1/1", pos, evt_bus.evt_dir); end
    endtask

    initial begin
        test_reset();
        test_cw_detent();
        test_saturation();
        test_jitter();
        test_overflow();
        test_back_to_back();
        test_err_en();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/quad_pos_ctrl.md
QUAD_POS_CTRL -- requirements
Module: quad_pos_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, width of position counter.
REQ-002 Parameter MAX_POS, default 255, upper saturation limit (SHALL be less than 2**WIDTH); lower limit fixed at 0.
REQ-003 Port clk  input  1  single system clock, all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port en  input  1  step-counting enable.
REQ-006 Port clr  input  1  synchronous clear of position, phase, and sticky flags.
REQ-007 Port a, b  input  1 each  debounced quadrature channels, already synchronous to clk.
REQ-008 Port evt_ready  input  1  consumer accepts the pending step event.
REQ-009 Port pos  output  WIDTH  current detent position.
REQ-010 Port at_min, at_max  output  1 each  pos==0 and pos==MAX_POS respectively.
REQ-011 Port evt_valid, evt_dir  output  1 each  step event pending; evt_dir=1 CW, 0 CCW.
REQ-012 Port evt_ovf  output  1  sticky: a step event was dropped.
REQ-013 Port err  output  1  sticky: illegal quadrature transition seen.

Function
REQ-014 Block SHALL hold prev={a,b} register; every edge prev SHALL load current {a,b}, regardless of en.
REQ-015 CW SHALL be transitions 00->01->11->10->00; CCW SHALL be the reverse; each legal CW transition SHALL add +1 to signed 3-bit-plus phase accumulator, CCW -1.
REQ-016 No change in {a,b} SHALL leave phase unchanged.
REQ-017 Both bits changing in one cycle SHALL set err, force phase to 0, and cause no step.
REQ-018 When phase reaches +4 a CW detent step SHALL occur and phase SHALL return to 0 on the same edge; -4 likewise for CCW.
REQ-019 Jitter (CW then CCW transitions) SHALL cancel in phase and produce no step.
REQ-020 On a CW step pos SHALL increment unless pos==MAX_POS, where it holds; CCW SHALL decrement unless pos==0, where it holds.
REQ-021 Every step, saturated or not, SHALL generate an event.
REQ-022 pos, at_min, at_max, evt_* SHALL be registered and reflect a step from the edge at which the completing {a,b} sample is taken (1-cycle latency from input change).
REQ-023 Event handshake: evt_valid SHALL remain high with evt_dir stable until a cycle with evt_ready=1.
REQ-024 Event accepted (evt_valid & evt_ready) with no new step SHALL clear evt_valid next edge.
REQ-025 New step in same cycle as acceptance SHALL load the new evt_dir and keep evt_valid=1.
REQ-026 New step while evt_valid=1 and evt_ready=0 SHALL drop the new event, set evt_ovf, keep the old event; pos still updates.
REQ-027 With en=0, phase, pos and events SHALL not change; err detection SHALL also be suppressed; prev SHALL still track inputs so enabling produces no spurious step.
REQ-028 clr SHALL set pos=0, phase=0, evt_valid=0, evt_ovf=0, err=0 and SHALL take priority over any step in that cycle.

Reset
REQ-029 rst SHALL have priority over clr and en.
REQ-030 On rst: pos=0, phase=0, evt_valid=0, evt_dir=0, evt_ovf=0, err=0, at_min=1, at_max=0, prev={a,b} sampled that edge.
REQ-031 Assertion mid-sequence SHALL discard partial phase; first step after release SHALL need four full transitions.

Verification
REQ-032 Reset with a=b=0, en=1, drive CW 00->01->11->10->00 one change per 4 cycles -> pos=1, evt_valid=1, evt_dir=1 one cycle after final 00 sample; at_min=0.
REQ-033 pos=255 (MAX_POS=255), one CW detent -> pos stays 255, at_max=1, evt_valid=1 evt_dir=1; one CCW detent -> pos=254.
REQ-034 Drive 00->01->00->01->11->10->00 -> exactly one CW step, pos increments by 1, no err.
REQ-035 Two CW detents with evt_ready=0 -> pos=2, evt_valid=1, evt_ovf=1; raise evt_ready one cycle -> evt_valid=0 next edge, evt_ovf stays 1 until clr.
REQ-036 Drive 00->11 in one cycle -> err=1, phase 0, pos unchanged; en=0 during a full CW detent -> pos unchanged, no event; clr with rst=0 -> pos=0, err=0, evt_ovf=0.
REQ-037 rst asserted after two CW transitions, released, then two more CW transitions -> no step, pos=0.
